// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: evaluates AND/OR/XOR/ADD (and SUB when
// SERIAL_ALU_SUB_EN is defined) LSB-first through a 1-bit slice.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op_r;
    logic [CW-1:0]    count;
    logic             carry;

    logic             accept;
    logic             last;
    logic             bit_s;
    logic             carry_s;
    logic             arith;
    logic [WIDTH-1:0] word;

    assign accept = (state == IDLE || state == DONE) && start;
    assign last   = (state == RUN) && (count == LAST);
    assign word   = {bit_s, acc[WIDTH-1:1]};
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One slice evaluation; undefined opcodes yield 0 with no carry.
    always_comb begin
        bit_s   = 1'b0;
        carry_s = carry;
        arith   = 1'b0;
        case (op_r)
            3'b000: bit_s = a_sh[0] & b_sh[0];
            3'b001: bit_s = a_sh[0] | b_sh[0];
            3'b010: bit_s = a_sh[0] ^ b_sh[0];
            3'b011: begin
                bit_s   = a_sh[0] ^ b_sh[0] ^ carry;
                carry_s = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry)
                        | (b_sh[0] & carry);
                arith   = 1'b1;
            end
`ifdef SERIAL_ALU_SUB_EN
            3'b100: begin
                bit_s   = a_sh[0] ^ ~b_sh[0] ^ carry;
                carry_s = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry)
                        | (~b_sh[0] & carry);
                arith   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            op_r      <= '0;
            count     <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            op_r  <= op;
            acc   <= '0;
            count <= '0;
`ifdef SERIAL_ALU_SUB_EN
            carry <= (op == 3'b100);
`else
            carry <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= word;
            carry <= carry_s;
            if (!last) begin
                count <= count + 1'b1;
            end else begin
                result    <= word;
                carry_out <= arith & carry_s;
                zero      <= (word == '0);
            end
        end
    end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial sequencer for the lab ALU datapath: accepts two WIDTH-bit operands and an opcode, then evaluates them LSB-first, one bit per clock, through a single 1-bit logic/adder slice. It drives the 1-bit gate cells bit by bit and presents a registered word result with a one-cycle `done` pulse. It sits between the register file/control FSM and the 1-bit slice library, trading latency for area against the parallel ALU.

## Interface
- `WIDTH`, 32, operand/result width; legal range 2..64.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `op`  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (see Configuration), others undefined.
- `a`  input  WIDTH  operand A; latched on accepted `start`.
- `b`  input  WIDTH  operand B; latched on accepted `start`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; result/flags valid.
- `result`  output  WIDTH  registered result; holds until next `done`.
- `carry_out`  output  1  final carry for ADD/SUB; 0 for all other ops.
- `zero`  output  1  high when `result` == 0; registered with `done`.

## Operation
- Reset (`rst_n` low, asynchronous): state IDLE; `busy`, `done`, `carry_out`, `zero` = 0; `result` = 0; internal count, carry and shift registers cleared.
- States: IDLE -> RUN on `start`; RUN -> DONE when bit WIDTH-1 processed; DONE -> RUN on `start`, else -> IDLE.
- Accept: in IDLE or DONE with `start`=1, latch `a`, `b`, `op`; count=0; carry init = 1 for SUB, else 0.
- RUN, per edge: slice bit `count`; logic ops use a[i] op b[i]; ADD sum = a[i]^b[i]^c, c' = majority; SUB uses ~b[i]. Bit shifted MSB-ward into internal shift register; count increments.
- `start` during RUN ignored; latched operands unaffected.
- Undefined opcodes: result 0, `carry_out` 0, `zero` 1.
- `result` output changes only on the `done` edge; stays stable during RUN.
- SUB `carry_out` = 1 means no borrow (a >= b unsigned).
- Count width = clog2(WIDTH); count never wraps past WIDTH-1.

## Timing
- E0: edge sampling accepted `start`; `busy` rises after E0.
- E1..EWIDTH: one bit per edge; at EWIDTH state -> DONE, `done`=1, `busy`=0, `result`/`carry_out`/`zero` updated.
- EWIDTH+1: `done`=0; a new `start` sampled here is accepted (back-to-back).
- Latency: WIDTH edges start-to-done; throughput one op per WIDTH+1 cycles... back-to-back: next `done` exactly WIDTH+1 cycles after previous `done` when `start` is held in DONE.
- `rst_n` asserted mid-RUN: abort immediately; no `done` for the aborted op; first `start` after release behaves normally.
- `rst_n` deassertion is synchronous-safe by the caller; block performs no internal synchronizer.

## Configuration
- `SERIAL_ALU_SUB_EN` defined: op 100 = SUB (a + ~b + 1), carry init 1.
- Not defined: op 100 treated as undefined (result 0, `carry_out` 0, `zero` 1); no inversion/carry-init logic compiled.

## Test plan
- WIDTH=8, OR a=0xA5 b=0x0F -> `done` 8 edges after start edge; result 0xAF, `carry_out` 0, `zero` 0.
- ADD 0xFF + 0x01 -> result 0x00, `carry_out` 1, `zero` 1; `busy` high exactly 8 cycles.
- Start XOR 0x3C^0xFF, then pulse `start` with AND 0x00,0x00 during RUN -> ignored; result 0xC3.
- `rst_n` low at count 3 of an ADD -> all outputs 0 asynchronously, no `done`; then OR 0x01|0x80 -> 0x81.
- Back-to-back: XOR 0x3C^0xFF then AND 0xF0&0x3C with `start` held in DONE -> 0xC3, then 0x30 exactly 9 cycles later.
- With `SERIAL_ALU_SUB_EN`: SUB 0x05-0x07 -> 0xFE, `carry_out` 0; without macro, op 100 -> 0x00, `zero` 1.
